// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush control for the ID/EX boundary of the pipeline.
// Freezes across multi-cycle SRAM accesses and keeps saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             pc_en,
  output logic             if_flush,
  output logic             id_frz,
  output logic             id_flush,
  output logic             exe_en,
  output logic             mem_en,
  output logic             mem_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          hit1, hit2, load_use, hazard;
  logic          advance, stall_inc, flush_inc, set_to;

  assign hit1 = (exe_wb_en & (src1 == exe_dest))
              | (mem_wb_en & (src1 == mem_dest));
  assign hit2 = two_src
              & ((exe_wb_en & (src2 == exe_dest))
              |  (mem_wb_en & (src2 == mem_dest)));
  assign load_use = exe_mem_read & exe_wb_en
                  & ((src1 == exe_dest)
                  |  (two_src & (src2 == exe_dest)));
  assign hazard = id_valid & (fwd_en ? load_use : (hit1 | hit2));

  assign mem_wait = (state == MEM_WAIT);

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    advance   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    set_to    = 1'b0;
    pc_en     = 1'b0;
    if_flush  = 1'b0;
    id_frz    = 1'b0;
    id_flush  = 1'b0;
    exe_en    = 1'b0;
    mem_en    = 1'b0;
    if (rst) begin
      unique case (state)
        RUN: begin
          if (mem_req & ~sram_ready) begin
            state_nxt = MEM_WAIT;
            stall_inc = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
        MEM_WAIT: begin
          stall_inc = 1'b1;
          if (sram_ready || wait_cnt == LAST) begin
            advance   = 1'b1;
            state_nxt = RUN;
            wait_nxt  = '0;
            set_to    = ~sram_ready;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
      // a taken branch squashes the ID instruction, so its hazard is moot
      if (advance) begin
        exe_en = 1'b1;
        mem_en = 1'b1;
        id_frz = 1'b1;
        unique case (1'b1)
          branch_taken: begin
            pc_en     = 1'b1;
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            flush_inc = 1'b1;
          end
          (~branch_taken & hazard): begin
            id_flush  = 1'b1;
            stall_inc = 1'b1;
          end
          default: pc_en = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (set_to)
        mem_timeout <= 1'b1;
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Small MEM_TIMEOUT and CNT_W keep timeout and saturation cases short.
module tb_pipe_hazard_ctrl;

  localparam int TO = 8;
  localparam int CW = 4;

  localparam logic [5:0] E_OFF  = 6'b000000;
  localparam logic [5:0] E_RUN  = 6'b101011;
  localparam logic [5:0] E_BUB  = 6'b001111;
  localparam logic [5:0] E_BR   = 6'b111111;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, two_src, exe_wb_en, exe_mem_read;
  logic          mem_wb_en, fwd_en, branch_taken, mem_req, sram_ready;
  logic [3:0]    src1, src2, exe_dest, mem_dest;
  logic          pc_en, if_flush, id_frz, id_flush, exe_en, mem_en;
  logic          mem_wait, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .fwd_en(fwd_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .sram_ready(sram_ready),
    .pc_en(pc_en), .if_flush(if_flush), .id_frz(id_frz),
    .id_flush(id_flush), .exe_en(exe_en), .mem_en(mem_en),
    .mem_wait(mem_wait), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [5:0] en();
    return {pc_en, if_flush, id_frz, id_flush, exe_en, mem_en};
  endfunction

  task automatic idle();
    id_valid = 0; two_src = 0; exe_wb_en = 0; exe_mem_read = 0;
    mem_wb_en = 0; fwd_en = 0; branch_taken = 0;
    mem_req = 0; sram_ready = 0;
    src1 = 0; src2 = 0; exe_dest = 0; mem_dest = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    cyc();
    rst = 1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #4;
    checks++;
    if (en() !== E_OFF) begin
      errors++;
      $display("FAIL reset_en got %b want %b", en(), E_OFF);
    end
    checks++;
    if ({mem_wait, mem_timeout, stall_cnt, flush_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_regs got %b %b %0d %0d want 0",
               mem_wait, mem_timeout, stall_cnt, flush_cnt);
    end
    cyc();
    rst = 1;
    #4;
    checks++;
    if (en() !== E_RUN) begin
      errors++;
      $display("FAIL idle_en got %b want %b", en(), E_RUN);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    fwd_en = 1; exe_mem_read = 1; exe_wb_en = 1;
    exe_dest = 3; src1 = 3; id_valid = 1;
    #4;
    checks++;
    if (en() !== E_BUB) begin
      errors++;
      $display("FAIL load_use_en got %b want %b", en(), E_BUB);
    end
    cyc();
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL load_use_cnt got %0d want 1", stall_cnt);
    end
    exe_mem_read = 0;
    #4;
    checks++;
    if (en() !== E_RUN) begin
      errors++;
      $display("FAIL fwd_alu_en got %b want %b", en(), E_RUN);
    end
    cyc();
    exe_mem_read = 1; id_valid = 0;
    #4;
    checks++;
    if (en() !== E_RUN || stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL invalid_id got %b/%0d want %b/1",
               en(), stall_cnt, E_RUN);
    end
    cyc();
  endtask

  task automatic test_raw_nofwd();
    do_reset();
    id_valid = 1; mem_wb_en = 1; mem_dest = 5;
    two_src = 1; src2 = 5; src1 = 1;
    #4;
    checks++;
    if (en() !== E_BUB) begin
      errors++;
      $display("FAIL raw_src2_en got %b want %b", en(), E_BUB);
    end
    cyc();
    two_src = 0;
    #4;
    checks++;
    if (en() !== E_RUN) begin
      errors++;
      $display("FAIL raw_one_src_en got %b want %b", en(), E_RUN);
    end
    cyc();
    two_src = 1; fwd_en = 1;
    #4;
    checks++;
    if (en() !== E_RUN || stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL raw_fwd got %b/%0d want %b/1",
               en(), stall_cnt, E_RUN);
    end
    cyc();
  endtask

  task automatic test_branch_hazard();
    do_reset();
    fwd_en = 1; exe_mem_read = 1; exe_wb_en = 1;
    exe_dest = 7; src1 = 7; id_valid = 1; branch_taken = 1;
    #4;
    checks++;
    if (en() !== E_BR) begin
      errors++;
      $display("FAIL branch_en got %b want %b", en(), E_BR);
    end
    cyc();
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL branch_cnt got f%0d s%0d want f1 s0",
               flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_sram_wait();
    int mw;
    do_reset();
    mw = 0;
    mem_req = 1; sram_ready = 1;
    #4;
    checks++;
    if (en() !== E_RUN || mem_wait !== 1'b0) begin
      errors++;
      $display("FAIL single_cycle got %b/%b want %b/0",
               en(), mem_wait, E_RUN);
    end
    cyc();
    sram_ready = 0;
    for (int i = 0; i < 4; i++) begin
      branch_taken = (i == 2);
      #4;
      if (mem_wait) mw++;
      checks++;
      if (en() !== E_OFF) begin
        errors++;
        $display("FAIL wait_en[%0d] got %b want %b", i, en(), E_OFF);
      end
      cyc();
    end
    branch_taken = 0;
    sram_ready = 1;
    #4;
    if (mem_wait) mw++;
    checks++;
    if (en() !== E_RUN) begin
      errors++;
      $display("FAIL release_en got %b want %b", en(), E_RUN);
    end
    cyc();
    mem_req = 0; sram_ready = 0;
    #4;
    if (mem_wait) mw++;
    checks++;
    if (mw !== 4) begin
      errors++;
      $display("FAIL wait_len got %0d want 4", mw);
    end
    checks++;
    if (stall_cnt !== 4'd5 || flush_cnt !== 4'd0) begin
      errors++;
      $display("FAIL wait_cnt got s%0d f%0d want s5 f0",
               stall_cnt, flush_cnt);
    end
    cyc();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1; sram_ready = 0;
    cyc();
    for (int k = 1; k <= TO; k++) begin
      if (k == TO) mem_req = 0;
      #4;
      checks++;
      if (mem_wait !== 1'b1 || mem_timeout !== 1'b0 ||
          en() !== ((k == TO) ? E_RUN : E_OFF)) begin
        errors++;
        $display("FAIL to_wait[%0d] got mw%b to%b en%b", k,
                 mem_wait, mem_timeout, en());
      end
      cyc();
    end
    for (int j = 0; j < 3; j++) cyc();
    checks++;
    if (mem_timeout !== 1'b1 || mem_wait !== 1'b0 ||
        stall_cnt !== 4'd9) begin
      errors++;
      $display("FAIL to_after got to%b mw%b s%0d want to1 mw0 s9",
               mem_timeout, mem_wait, stall_cnt);
    end
    rst = 0;
    #1;
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear got %b want 0", mem_timeout);
    end
    rst = 1;
  endtask

  task automatic test_reset_midwait();
    do_reset();
    mem_req = 1; sram_ready = 0;
    cyc();
    cyc();
    rst = 0;
    #1;
    checks++;
    if (mem_wait !== 1'b0 || stall_cnt !== 4'd0 || en() !== E_OFF) begin
      errors++;
      $display("FAIL midwait_rst got mw%b s%0d en%b want 0 0 %b",
               mem_wait, stall_cnt, en(), E_OFF);
    end
    idle();
    cyc();
    rst = 1;
    #4;
    checks++;
    if (en() !== E_RUN) begin
      errors++;
      $display("FAIL midwait_resume got %b want %b", en(), E_RUN);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    id_valid = 1; mem_wb_en = 1; mem_dest = 2; src1 = 2;
    for (int i = 0; i < 20; i++) cyc();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_sat got %0d want 15", stall_cnt);
    end
    branch_taken = 1;
    for (int i = 0; i < 20; i++) cyc();
    checks++;
    if (flush_cnt !== 4'd15 || stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL flush_sat got f%0d s%0d want 15 15",
               flush_cnt, stall_cnt);
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 0;
    #1;
    test_reset();
    test_load_use();
    test_raw_nofwd();
    test_branch_hazard();
    test_sram_wait();
    test_timeout();
    test_reset_midwait();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control-side counterpart of the ID/EX pipeline register.
- Generates the frz (load-enable, active-high) and flush controls consumed by that register, plus enables for the IF/ID, PC and later stages.
- Detects RAW hazards between the ID-stage sources and the EXE/MEM destinations, handles taken branches, and freezes the pipeline across multi-cycle SRAM accesses.
- Keeps saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before forced release.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- src1  in  4  ID source register 1
- src2  in  4  ID source register 2
- two_src  in  1  ID instruction reads src2
- exe_dest  in  4  destination register in EXE
- exe_wb_en  in  1  EXE writes back
- exe_mem_read  in  1  EXE instruction is a load
- mem_dest  in  4  destination register in MEM
- mem_wb_en  in  1  MEM writes back
- fwd_en  in  1  forwarding unit enabled
- branch_taken  in  1  EXE resolved a taken branch
- mem_req  in  1  MEM stage performing a read or write
- sram_ready  in  1  SRAM completes access this cycle
- pc_en  out  1  PC and IF/ID load enable
- if_flush  out  1  clear IF/ID
- id_frz  out  1  ID/EX load enable
- id_flush  out  1  with id_frz=1, clears ID/EX
- exe_en  out  1  EXE/MEM load enable
- mem_en  out  1  MEM/WB load enable
- mem_wait  out  1  FSM in MEM_WAIT
- mem_timeout  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  stall cycles, saturating
- flush_cnt  out  CNT_W  branch flushes, saturating

Behaviour:
- Reset (rst=0, async):
  - State RUN; wait counter, stall_cnt, flush_cnt and mem_timeout cleared to 0.
  - While rst=0, all enables and flushes are 0.
- hazard (combinational), gated by id_valid:
  - hit1 = (exe_wb_en & src1==exe_dest) | (mem_wb_en & src1==mem_dest)
  - hit2 = two_src & ((exe_wb_en & src2==exe_dest) | (mem_wb_en & src2==mem_dest))
  - fwd_en=0: hazard = hit1 | hit2.
  - fwd_en=1: hazard only for a load-use: exe_mem_read & exe_wb_en & (src1==exe_dest | (two_src & src2==exe_dest)).
- RUN state outputs, priority order:
  1. mem_req & !sram_ready: all enables 0, flushes 0; next state MEM_WAIT; stall_cnt+1.
  2. branch_taken: pc_en=1, if_flush=1, id_frz=1, id_flush=1, exe_en=mem_en=1; flush_cnt+1. A simultaneous hazard is ignored because the ID instruction is squashed.
  3. hazard: pc_en=0, if_flush=0, id_frz=1, id_flush=1 (bubble), exe_en=mem_en=1; stall_cnt+1.
  4. Otherwise: all enables 1, flushes 0.
  - mem_req & sram_ready in RUN is a single-cycle access: treated as case 2/3/4, no wait.
- MEM_WAIT state:
  - All enables 0, flushes 0; mem_wait=1; wait counter +1 per cycle; stall_cnt+1 per cycle.
  - branch_taken and hazard are ignored because EXE is held.
  - On sram_ready=1: this cycle uses RUN output rules 2-4 (access completes, pipeline advances); next state RUN; wait counter cleared.
  - If the wait counter reaches MEM_TIMEOUT without sram_ready: mem_timeout<=1 (sticky until reset), forced release identical to a sram_ready cycle.
- The FSM and counters are the only registers; enables and flushes are combinational from state and inputs, with no added latency.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-wait: immediate return to RUN, everything cleared; the in-flight access is the SRAM controller's concern.
- Asserting id_flush always implies id_frz=1, so the ID/EX register clears rather than holds.

Test Plan:
- Load-use: fwd_en=1, exe_mem_read=1, exe_wb_en=1, exe_dest=3, src1=3, id_valid=1 -> one cycle with pc_en=0, id_frz=1, id_flush=1; stall_cnt 0->1.
- No-forward RAW: fwd_en=0, mem_wb_en=1, mem_dest=5, two_src=1, src2=5 -> bubble; with two_src=0 -> no stall, all enables 1.
- Branch plus hazard in the same cycle: branch_taken=1 and hazard=1 -> if_flush=1, id_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- SRAM wait: mem_req=1, sram_ready=0 for 4 cycles then 1 -> mem_wait high for exactly 4 cycles with all enables 0; release cycle has all enables 1; stall_cnt=5.
- Timeout: MEM_TIMEOUT=8, sram_ready held 0 -> forced release after 8 MEM_WAIT cycles; mem_timeout=1 and stays 1 until rst=0.
- Reset mid-wait plus saturation: rst=0 during MEM_WAIT -> state RUN, counters 0 immediately; with CNT_W=4, 20 stall cycles -> stall_cnt=15.
